// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM state encoding
// and the baud-rate divider constant.
package uart_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_BIT = 3'd1,
      DATA_BITS = 3'd2,
      STOP_BIT  = 3'd3,
      CLEAN_UP  = 3'd4
   } uart_state_e;

   function automatic int bit_cycles(input int freq, input int baud_rate);
      return freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: while run is high it counts clocks and flags the last
// clock of each bit period, then restarts from zero on its own.
module uart_bit_timer #(
   parameter int BIT_CYCLES = 2500
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic bit_done
);

   localparam int CW = $clog2(2 * BIT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign bit_done = run && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (clear || bit_done) begin
         count_d = '0;
      end else if (run) begin
         count_d = count_q + CW'(1);
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register so that a queued byte
// follows the current frame's stop bit with no idle gap.
module uart_tx
   import uart_pkg::*;
#(
   parameter int FREQ      = 24_000_000,
   parameter int BAUD_RATE = 9600,
   parameter int STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_start,
   input  logic [DATA_W-1:0] DATA_byte,
   output logic              tx_ready,
   output logic              tx_busy,
   output logic              done_tick,
   output logic              tx_serial
);

   localparam int BIT_CYCLES = bit_cycles(FREQ, BAUD_RATE);
   localparam int STOP_N = (STOP_BITS == 2) ? 2 : 1;
   localparam logic [2:0] STOP_LAST = 3'(STOP_N - 1);

   uart_state_e       state_q, state_d;
   logic [DATA_W-1:0] hold_data_q, hold_data_d;
   logic              hold_valid_q, hold_valid_d;
   logic [DATA_W-1:0] shifter_q, shifter_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic              frame_end_q, frame_end_d;
   logic              tx_serial_q, tx_serial_d;
   logic              tx_ready_q, tx_ready_d;
   logic              tx_busy_q, tx_busy_d;
   logic              done_tick_q, done_tick_d;

   logic accept;
   logic timer_clear;
   logic timer_run;
   logic bit_done;

   assign accept = tx_start && tx_ready_q;

   uart_bit_timer #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_bit_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear),
      .run     (timer_run),
      .bit_done(bit_done)
   );

   always_comb begin
      state_d      = state_q;
      hold_data_d  = hold_data_q;
      hold_valid_d = hold_valid_q;
      shifter_d    = shifter_q;
      bit_idx_d    = bit_idx_q;
      frame_end_d  = 1'b0;
      timer_clear  = 1'b0;
      timer_run    = 1'b0;

      if (accept) begin
         hold_data_d  = DATA_byte;
         hold_valid_d = 1'b1;
      end else begin
         hold_valid_d = hold_valid_q;
      end

      case (state_q)
         IDLE: begin
            if (hold_valid_q) begin
               shifter_d    = hold_data_q;
               hold_valid_d = 1'b0;
               timer_clear  = 1'b1;
               state_d      = START_BIT;
            end else begin
               state_d = IDLE;
            end
         end
         START_BIT: begin
            timer_run = 1'b1;
            if (bit_done) begin
               bit_idx_d = 3'd0;
               state_d   = DATA_BITS;
            end else begin
               state_d = START_BIT;
            end
         end
         DATA_BITS: begin
            timer_run = 1'b1;
            if (bit_done) begin
               shifter_d = {1'b0, shifter_q[DATA_W-1:1]};
               if (bit_idx_q == 3'd7) begin
                  bit_idx_d = 3'd0;
                  state_d   = STOP_BIT;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               state_d = DATA_BITS;
            end
         end
         STOP_BIT: begin
            timer_run = 1'b1;
            // bit_idx doubles as the stop-bit counter for the two-stop-bit mode
            if (bit_done && (bit_idx_q == STOP_LAST)) begin
               frame_end_d = 1'b1;
               bit_idx_d   = 3'd0;
               if (hold_valid_q) begin
                  shifter_d    = hold_data_q;
                  hold_valid_d = 1'b0;
                  timer_clear  = 1'b1;
                  state_d      = START_BIT;
               end else begin
                  state_d = CLEAN_UP;
               end
            end else if (bit_done) begin
               bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               state_d = STOP_BIT;
            end
         end
         CLEAN_UP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      tx_ready_d  = !hold_valid_d;
      done_tick_d = frame_end_q;
   end

   always_comb begin
      tx_serial_d = 1'b1;
      tx_busy_d   = 1'b0;
      case (state_q)
         IDLE: begin
            tx_serial_d = 1'b1;
            tx_busy_d   = 1'b0;
         end
         START_BIT: begin
            tx_serial_d = 1'b0;
            tx_busy_d   = 1'b1;
         end
         DATA_BITS: begin
            tx_serial_d = shifter_q[0];
            tx_busy_d   = 1'b1;
         end
         STOP_BIT, CLEAN_UP: begin
            tx_serial_d = 1'b1;
            tx_busy_d   = 1'b1;
         end
         default: begin
            tx_serial_d = 1'b1;
            tx_busy_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         hold_data_q  <= '0;
         hold_valid_q <= 1'b0;
         shifter_q    <= '0;
         bit_idx_q    <= 3'd0;
         frame_end_q  <= 1'b0;
         tx_serial_q  <= 1'b1;
         tx_ready_q   <= 1'b1;
         tx_busy_q    <= 1'b0;
         done_tick_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_data_q  <= hold_data_d;
         hold_valid_q <= hold_valid_d;
         shifter_q    <= shifter_d;
         bit_idx_q    <= bit_idx_d;
         frame_end_q  <= frame_end_d;
         tx_serial_q  <= tx_serial_d;
         tx_ready_q   <= tx_ready_d;
         tx_busy_q    <= tx_busy_d;
         done_tick_q  <= done_tick_d;
      end
   end

   assign tx_serial = tx_serial_q;
   assign tx_ready  = tx_ready_q;
   assign tx_busy   = tx_busy_q;
   assign done_tick = done_tick_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: one instance with one stop bit, one with two.
// Expected frames come from a timing model of the line; monitors decode the line.
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int FREQ = 1_000_000;
   localparam int BAUD = 100_000;
   localparam int BITC = 10;

   typedef struct {
      int         start;
      logic [7:0] data;
   } frame_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, tx_start, tx_ready, tx_busy, done_tick, tx_serial;
   logic [7:0] data_byte;
   logic       s2_reset, s2_start, s2_ready, s2_busy, s2_done, s2_serial;
   logic [7:0] s2_data;

   uart_tx #(.FREQ(FREQ), .BAUD_RATE(BAUD), .STOP_BITS(1)) dut (
      .clk(clk), .reset(reset), .tx_start(tx_start), .DATA_byte(data_byte),
      .tx_ready(tx_ready), .tx_busy(tx_busy), .done_tick(done_tick), .tx_serial(tx_serial));

   uart_tx #(.FREQ(FREQ), .BAUD_RATE(BAUD), .STOP_BITS(2)) dut2 (
      .clk(clk), .reset(s2_reset), .tx_start(s2_start), .DATA_byte(s2_data),
      .tx_ready(s2_ready), .tx_busy(s2_busy), .done_tick(s2_done), .tx_serial(s2_serial));

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_start [2];
   frame_t exp_q0 [$];
   frame_t exp_q1 [$];
   int done_q0 [$];
   int done_q1 [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name, input int act);
      checks++;
      errors++;
      $display("FAIL %s: observed %0d at cycle %0d", name, act, cyc);
   endtask

   function automatic int frame_len(input int w);
      return (w == 1) ? 11 * BITC : 10 * BITC;
   endfunction

   function automatic logic line_of(input int w);
      return (w == 1) ? s2_serial : tx_serial;
   endfunction

   function automatic logic rst_of(input int w);
      return (w == 1) ? s2_reset : reset;
   endfunction

   function automatic logic ready_of(input int w);
      return (w == 1) ? s2_ready : tx_ready;
   endfunction

   // Line model: a frame starts two edges after acceptance once the line is
   // free; a byte queued before the last stop clock follows immediately,
   // otherwise the clean-up cycle and idle load add a gap.
   task automatic model_push(input int w, input logic [7:0] b, input int acc);
      int fl;
      int st;
      frame_t f;
      fl = frame_len(w);
      if (acc <= last_start[w] + fl - 2) st = last_start[w] + fl;
      else if (acc + 2 > last_start[w] + fl + 2) st = acc + 2;
      else st = last_start[w] + fl + 2;
      last_start[w] = st;
      f.start = st;
      f.data = b;
      if (w == 1) begin
         exp_q1.push_back(f);
         done_q1.push_back(st + fl);
      end else begin
         exp_q0.push_back(f);
         done_q0.push_back(st + fl);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int w, input logic [7:0] b, output int acc);
      int n;
      n = 0;
      while (ready_of(w) !== 1'b1 && n < 500) begin
         tick(1);
         n++;
      end
      if (n >= 500) fail("ready_timeout", w);
      if (w == 1) begin
         s2_start = 1'b1;
         s2_data = b;
      end else begin
         tx_start = 1'b1;
         data_byte = b;
      end
      tick(1);
      acc = cyc;
      s2_start = 1'b0;
      tx_start = 1'b0;
      model_push(w, b, acc);
   endtask

   task automatic line_monitor(input int w);
      frame_t f;
      int fl;
      int bad;
      int st;
      logic [7:0] got;
      logic [10:0] bits;
      logic ln;
      bit abort;
      bit have;
      forever begin
         @(negedge clk);
         if (rst_of(w) === 1'b1 || line_of(w) !== 1'b0) continue;
         st = cyc;
         fl = frame_len(w);
         have = (w == 1) ? (exp_q1.size() > 0) : (exp_q0.size() > 0);
         if (have) begin
            f = (w == 1) ? exp_q1.pop_front() : exp_q0.pop_front();
            check("frame_start", st, f.start);
            bits = {2'b11, f.data, 1'b0};
         end else begin
            fail("unexpected_frame", w);
            bits = '1;
         end
         bad = 0;
         abort = 1'b0;
         got = '0;
         for (int k = 0; k < fl; k++) begin
            if (k > 0) @(negedge clk);
            if (rst_of(w) === 1'b1) begin
               abort = 1'b1;
               break;
            end
            ln = line_of(w);
            if (ln !== bits[k / BITC]) bad++;
            if ((k % BITC) == BITC / 2 && k / BITC >= 1 && k / BITC <= 8) got[k / BITC - 1] = ln;
         end
         if (!abort && have) begin
            check("frame_byte", got, f.data);
            check("frame_bad_cycles", bad, 0);
         end
      end
   endtask

   initial line_monitor(0);
   initial line_monitor(1);

   // Every done pulse must land on the cycle the model predicted for the oldest frame.
   always @(negedge clk) begin
      if (done_tick !== 1'b0) begin
         if (done_q0.size() == 0) fail("unexpected_done", 0);
         else check("done_cycle", cyc, done_q0.pop_front());
      end
      if (s2_done !== 1'b0) begin
         if (done_q1.size() == 0) fail("unexpected_done2", 1);
         else check("done_cycle2", cyc, done_q1.pop_front());
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int n;
      logic [7:0] b;
      last_start[0] = -1000;
      last_start[1] = -1000;
      reset = 1'b1;
      s2_reset = 1'b1;
      tx_start = 1'b0;
      s2_start = 1'b0;
      data_byte = 8'h00;
      s2_data = 8'h00;
      tick(3);
      check("rst_serial", tx_serial, 1'b1);
      check("rst_ready", tx_ready, 1'b1);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_done", done_tick, 1'b0);
      reset = 1'b0;
      s2_reset = 1'b0;
      tick(50);
      check("idle_serial", tx_serial, 1'b1);
      check("idle_ready", tx_ready, 1'b1);
      check("idle_busy", tx_busy, 1'b0);
      check("idle2_serial", s2_serial, 1'b1);

      // Single frame 0xA5 with ready/busy timing
      send(0, 8'hA5, acc);
      check("ready_drop", tx_ready, 1'b0);
      tick(1);
      check("ready_back", tx_ready, 1'b1);
      tick(101);
      check("busy_at_done", tx_busy, 1'b1);
      tick(1);
      check("busy_after_done", tx_busy, 1'b0);
      tick(20);

      // Back-to-back frames
      send(0, 8'h00, acc);
      send(0, 8'hFF, acc);
      tick(250);

      // Write while not ready is dropped
      send(0, 8'h3C, acc);
      check("ignored_ready", tx_ready, 1'b0);
      tx_start = 1'b1;
      data_byte = 8'h99;
      tick(1);
      tx_start = 1'b0;
      tick(150);

      // Reset during data bit 4
      send(0, 8'h55, acc);
      tick(56);
      reset = 1'b1;
      exp_q0.delete();
      done_q0.delete();
      last_start[0] = -1000;
      tick(1);
      reset = 1'b0;
      check("abort_serial", tx_serial, 1'b1);
      check("abort_ready", tx_ready, 1'b1);
      check("abort_busy", tx_busy, 1'b0);
      tick(5);
      send(0, 8'h81, acc);
      tick(130);

      // Two stop bits
      send(1, 8'h01, acc);
      tick(130);

      // Randomised traffic on both instances
      for (int i = 0; i < 12; i++) begin
         b = 8'($urandom);
         send(0, b, acc);
         if (i % 3 == 0) begin
            b = 8'($urandom);
            send(1, b, acc);
         end
         tick($urandom_range(0, 120));
      end

      n = 0;
      while ((exp_q0.size() + exp_q1.size() + done_q0.size() + done_q1.size()) != 0 && n < 3000) begin
         tick(1);
         n++;
      end
      tick(20);
      check("pending_frames", exp_q0.size() + exp_q1.size(), 0);
      check("pending_done", done_q0.size() + done_q1.size(), 0);
      check("final_serial", tx_serial, 1'b1);
      check("final_busy", tx_busy, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
